// File: rtl/check_packets_pkg.sv
// Shared USB PID constants and PID class decoding for the packet scoreboard.
package check_packets_pkg;

    localparam int PID_W = 4;
    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        PID_RSVD  = 4'b0000,
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_e;

    typedef enum logic [1:0] {
        CLS_TOKEN,
        CLS_DATA,
        CLS_HSK,
        CLS_OTHER
    } pid_class_e;

    function automatic pid_class_e pid_class(input logic [3:0] pid);
        pid_class_e cls;
        case (pid)
            PID_OUT, PID_IN, PID_SOF, PID_SETUP: cls = CLS_TOKEN;
            PID_DATA0, PID_DATA1:                cls = CLS_DATA;
            PID_ACK, PID_NAK, PID_STALL:         cls = CLS_HSK;
            default:                             cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/check_packets_fifo.sv
// Expected-packet FIFO; pointers carry a wrap bit so full and empty are distinguishable.
module check_packets_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wptr, r_rptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_rd, w_wr;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // A pop frees the slot this cycle, so a push on a full FIFO still lands.
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/check_packets.sv
// Packet scoreboard: queues sender packets, compares each received packet against the queue head.
// Optional first-fail PID latch enabled by CHECK_PACKETS_FIRSTERR_EN.
module check_packets
    import check_packets_pkg::*;
#(
    parameter int MAX_PKT = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_exp_valid,
    input  logic                       i_exp_ready,
    input  logic [3:0]                 i_exp_pid,
    input  logic [8*MAX_PKT-1:0]       i_exp_data,
    input  logic [$clog2(MAX_PKT):0]   i_exp_nBytes,
    input  logic                       i_got_valid,
    input  logic [3:0]                 i_got_pid,
    input  logic [8*MAX_PKT-1:0]       i_got_data,
    input  logic [$clog2(MAX_PKT):0]   i_got_nBytes,
    output logic                       o_chk_valid,
    output logic                       o_chk_pass,
    output logic [15:0]                o_nPass,
    output logic [15:0]                o_nFail,
    output logic                       o_overflow,
    output logic                       o_underflow,
    output logic [3:0]                 o_firstErr_exp,
    output logic [3:0]                 o_firstErr_got
);
    localparam int NB_W = $clog2(MAX_PKT) + 1;
    localparam int DW   = 8 * MAX_PKT;
    localparam int EW   = PID_W + DW + NB_W;

    logic              w_push;
    logic              w_full, w_empty;
    logic [EW-1:0]     w_head;
    logic [3:0]        w_head_pid;
    logic [DW-1:0]     w_head_data;
    logic [NB_W-1:0]   w_head_nb;
    logic [MAX_PKT-1:0] w_byte_ok;
    logic              w_pass, w_res;

    assign w_push = i_exp_valid && i_exp_ready;

    check_packets_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (i_got_valid),
        .i_wdata ({i_exp_pid, i_exp_data, i_exp_nBytes}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_pid  = w_head[EW-1 -: PID_W];
    assign w_head_data = w_head[NB_W +: DW];
    assign w_head_nb   = w_head[NB_W-1:0];

    // Bytes at or beyond the expected length are don't-care.
    for (genvar b = 0; b < MAX_PKT; b++) begin : g_byte
        assign w_byte_ok[b] = (NB_W'(b) >= w_head_nb) ||
                              (w_head_data[8*b +: 8] == i_got_data[8*b +: 8]);
    end

    always_comb begin
        w_pass = 1'b0;
        case (pid_class(w_head_pid))
            CLS_TOKEN: w_pass = (w_head_pid == i_got_pid) && (w_head_data[10:0] == i_got_data[10:0]);
            CLS_DATA:  w_pass = (w_head_pid == i_got_pid) && (w_head_nb == i_got_nBytes) && (&w_byte_ok);
            CLS_HSK:   w_pass = (w_head_pid == i_got_pid);
            default:   w_pass = 1'b0;
        endcase
    end

    assign w_res = w_pass && !w_empty;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_chk_valid <= 1'b0;
            o_chk_pass  <= 1'b0;
            o_nPass     <= '0;
            o_nFail     <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_chk_valid <= i_got_valid;
            o_chk_pass  <= i_got_valid && w_res;
            if (i_got_valid) begin
                if (w_res) begin
                    if (o_nPass != 16'hFFFF) o_nPass <= o_nPass + 16'd1;
                end else begin
                    if (o_nFail != 16'hFFFF) o_nFail <= o_nFail + 16'd1;
                end
            end
            if (w_push && w_full && !i_got_valid) o_overflow <= 1'b1;
            if (i_got_valid && w_empty)           o_underflow <= 1'b1;
        end
    end

`ifdef CHECK_PACKETS_FIRSTERR_EN
    logic r_err_seen;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_err_seen     <= 1'b0;
            o_firstErr_exp <= '0;
            o_firstErr_got <= '0;
        end else if (i_got_valid && !w_res && !r_err_seen) begin
            r_err_seen     <= 1'b1;
            o_firstErr_exp <= w_empty ? PID_RSVD : w_head_pid;
            o_firstErr_got <= i_got_pid;
        end
    end
`else
    assign o_firstErr_exp = '0;
    assign o_firstErr_got = '0;
`endif

endmodule

// File: tb/tb_check_packets.sv
// Directed self-checking bench for check_packets (MAX_PKT=8, DEPTH=4).
module tb_check_packets;
    import check_packets_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_exp_valid = 1'b0, i_exp_ready = 1'b0;
    logic [3:0]  i_exp_pid = '0;
    logic [63:0] i_exp_data = '0;
    logic [3:0]  i_exp_nBytes = '0;
    logic        i_got_valid = 1'b0;
    logic [3:0]  i_got_pid = '0;
    logic [63:0] i_got_data = '0;
    logic [3:0]  i_got_nBytes = '0;
    logic        o_chk_valid, o_chk_pass, o_overflow, o_underflow;
    logic [15:0] o_nPass, o_nFail;
    logic [3:0]  o_firstErr_exp, o_firstErr_got;

    int n_chk = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    check_packets #(.MAX_PKT(8), .DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_exp_valid(i_exp_valid), .i_exp_ready(i_exp_ready), .i_exp_pid(i_exp_pid),
        .i_exp_data(i_exp_data), .i_exp_nBytes(i_exp_nBytes),
        .i_got_valid(i_got_valid), .i_got_pid(i_got_pid), .i_got_data(i_got_data),
        .i_got_nBytes(i_got_nBytes),
        .o_chk_valid(o_chk_valid), .o_chk_pass(o_chk_pass), .o_nPass(o_nPass), .o_nFail(o_nFail),
        .o_overflow(o_overflow), .o_underflow(o_underflow),
        .o_firstErr_exp(o_firstErr_exp), .o_firstErr_got(o_firstErr_got)
    );

    task automatic do_reset();
        @(negedge i_clk); i_rst = 1'b0;
        @(negedge i_clk); i_rst = 1'b1;
    endtask

    task automatic push(input logic [3:0] pid, input logic [63:0] d, input logic [3:0] nb);
        @(negedge i_clk);
        i_exp_valid = 1'b1; i_exp_ready = 1'b1;
        i_exp_pid = pid; i_exp_data = d; i_exp_nBytes = nb;
        @(negedge i_clk);
        i_exp_valid = 1'b0; i_exp_ready = 1'b0;
    endtask

    // Result is sampled one full cycle after the got pulse was presented.
    task automatic got(input logic [3:0] pid, input logic [63:0] d, input logic [3:0] nb,
                       output logic v, output logic p);
        @(negedge i_clk);
        i_got_valid = 1'b1; i_got_pid = pid; i_got_data = d; i_got_nBytes = nb;
        @(negedge i_clk);
        i_got_valid = 1'b0;
        v = o_chk_valid; p = o_chk_pass;
    endtask

    task automatic both(input logic [3:0] epid, input logic [63:0] ed,
                        input logic [3:0] gpid, input logic [63:0] gd,
                        output logic v, output logic p);
        @(negedge i_clk);
        i_exp_valid = 1'b1; i_exp_ready = 1'b1; i_exp_pid = epid; i_exp_data = ed; i_exp_nBytes = 4'd2;
        i_got_valid = 1'b1; i_got_pid = gpid; i_got_data = gd; i_got_nBytes = 4'd2;
        @(negedge i_clk);
        i_exp_valid = 1'b0; i_exp_ready = 1'b0; i_got_valid = 1'b0;
        v = o_chk_valid; p = o_chk_pass;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge i_clk);
        n_chk++; if ({o_chk_valid, o_chk_pass, o_overflow, o_underflow} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {o_chk_valid, o_chk_pass, o_overflow, o_underflow}); end
        n_chk++; if ({o_nPass, o_nFail} !== 32'h0) begin
            n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", o_nPass, o_nFail); end
        n_chk++; if ({o_firstErr_exp, o_firstErr_got} !== 8'h0) begin
            n_fail++; $display("FAIL reset_firsterr: got %h want 00", {o_firstErr_exp, o_firstErr_got}); end
        @(negedge i_clk); i_rst = 1'b1;
    endtask

    task automatic test_token();
        logic v, p;
        push(PID_OUT, 64'h07FF, 4'd2);
        got(PID_OUT, 64'hF7FF, 4'd7, v, p);
        n_chk++; if ({v, p} !== 2'b11) begin n_fail++; $display("FAIL token_pass: got v=%b p=%b want 1 1", v, p); end
        n_chk++; if (o_nPass !== 16'd1) begin n_fail++; $display("FAIL token_npass: got %0d want 1", o_nPass); end
        @(negedge i_clk);
        n_chk++; if (o_chk_valid !== 1'b0) begin n_fail++; $display("FAIL chk_valid_pulse: got %b want 0", o_chk_valid); end
    endtask

    task automatic test_data();
        logic v, p;
        push(PID_DATA0, 64'h0000_0000_00AA_BBCC, 4'd3);
        got(PID_DATA0, 64'h0000_5500_00AA_BBCC, 4'd3, v, p);
        n_chk++; if ({v, p} !== 2'b11) begin n_fail++; $display("FAIL data_pass: got v=%b p=%b want 1 1", v, p); end
        push(PID_DATA0, 64'h0000_0000_00AA_BBCC, 4'd3);
        got(PID_DATA0, 64'h0000_5500_00AA_BBCC, 4'd4, v, p);
        n_chk++; if ({v, p} !== 2'b10) begin n_fail++; $display("FAIL data_nbytes: got v=%b p=%b want 1 0", v, p); end
        n_chk++; if ({o_nPass, o_nFail} !== {16'd2, 16'd1}) begin
            n_fail++; $display("FAIL data_counts: got %0d/%0d want 2/1", o_nPass, o_nFail); end
        push(PID_DATA1, 64'h0000_0000_0000_1234, 4'd2);
        got(PID_DATA1, 64'h0000_0000_0000_1334, 4'd2, v, p);
        n_chk++; if ({v, p} !== 2'b10) begin n_fail++; $display("FAIL data_byte: got v=%b p=%b want 1 0", v, p); end
    endtask

    task automatic test_handshake();
        logic v, p;
        do_reset();
        push(PID_ACK, 64'h0, 4'd5);
        got(PID_ACK, 64'hFF, 4'd0, v, p);
        n_chk++; if ({v, p} !== 2'b11) begin n_fail++; $display("FAIL hsk_pass: got v=%b p=%b want 1 1", v, p); end
        push(PID_ACK, 64'h0, 4'd5);
        got(PID_NAK, 64'h0, 4'd5, v, p);
        n_chk++; if ({v, p} !== 2'b10) begin n_fail++; $display("FAIL hsk_pid: got v=%b p=%b want 1 0", v, p); end
`ifdef CHECK_PACKETS_FIRSTERR_EN
        n_chk++; if ({o_firstErr_exp, o_firstErr_got} !== {PID_ACK, PID_NAK}) begin
            n_fail++; $display("FAIL firsterr_latch: got %h want %h", {o_firstErr_exp, o_firstErr_got}, {PID_ACK, PID_NAK}); end
`else
        n_chk++; if ({o_firstErr_exp, o_firstErr_got} !== 8'h0) begin
            n_fail++; $display("FAIL firsterr_tied: got %h want 00", {o_firstErr_exp, o_firstErr_got}); end
`endif
        push(PID_RSVD, 64'h0, 4'd0);
        got(PID_RSVD, 64'h0, 4'd0, v, p);
        n_chk++; if ({v, p} !== 2'b10) begin n_fail++; $display("FAIL other_pid: got v=%b p=%b want 1 0", v, p); end
    endtask

    task automatic test_underflow();
        logic v, p;
        // Valid without ready must not enqueue.
        @(negedge i_clk); i_exp_valid = 1'b1; i_exp_pid = PID_OUT; i_exp_data = 64'h0;
        @(negedge i_clk); i_exp_valid = 1'b0;
        got(PID_IN, 64'h0, 4'd0, v, p);
        n_chk++; if ({v, p, o_underflow} !== 3'b101) begin
            n_fail++; $display("FAIL underflow: got v=%b p=%b uf=%b want 1 0 1", v, p, o_underflow); end
        n_chk++; if (o_nFail !== 16'd3) begin n_fail++; $display("FAIL underflow_nfail: got %0d want 3", o_nFail); end
`ifdef CHECK_PACKETS_FIRSTERR_EN
        n_chk++; if ({o_firstErr_exp, o_firstErr_got} !== {PID_ACK, PID_NAK}) begin
            n_fail++; $display("FAIL firsterr_hold: got %h want %h", {o_firstErr_exp, o_firstErr_got}, {PID_ACK, PID_NAK}); end
`endif
        do_reset();
        got(PID_IN, 64'h0, 4'd0, v, p);
`ifdef CHECK_PACKETS_FIRSTERR_EN
        n_chk++; if ({o_firstErr_exp, o_firstErr_got} !== {PID_RSVD, PID_IN}) begin
            n_fail++; $display("FAIL firsterr_uf: got %h want %h", {o_firstErr_exp, o_firstErr_got}, {PID_RSVD, PID_IN}); end
`endif
    endtask

    task automatic test_overflow();
        logic v, p;
        logic [3:0] pids [5];
        int npass;
        pids = '{PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_ACK};
        do_reset();
        for (int i = 0; i < 5; i++) push(pids[i], 64'(i), 4'd2);
        n_chk++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow: got %b want 1", o_overflow); end
        npass = 0;
        for (int i = 0; i < 4; i++) begin
            got(pids[i], 64'(i), 4'd2, v, p);
            if (v && p) npass++;
        end
        n_chk++; if (npass != 4) begin n_fail++; $display("FAIL overflow_order: got %0d passes want 4", npass); end
        got(PID_ACK, 64'h4, 4'd2, v, p);
        n_chk++; if ({p, o_underflow} !== 2'b01) begin
            n_fail++; $display("FAIL overflow_dropped: got p=%b uf=%b want 0 1", p, o_underflow); end
    endtask

    task automatic test_back_to_back();
        logic v, p;
        int npass;
        do_reset();
        for (int i = 1; i <= 4; i++) push(PID_OUT, 64'(i), 4'd2);
        both(PID_OUT, 64'h5, PID_OUT, 64'h1, v, p);
        n_chk++; if ({v, p, o_overflow} !== 3'b110) begin
            n_fail++; $display("FAIL full_pushpop: got v=%b p=%b of=%b want 1 1 0", v, p, o_overflow); end
        npass = 0;
        for (int i = 2; i <= 5; i++) begin
            got(PID_OUT, 64'(i), 4'd2, v, p);
            if (v && p) npass++;
        end
        n_chk++; if (npass != 4) begin n_fail++; $display("FAIL full_occupancy: got %0d passes want 4", npass); end
        got(PID_OUT, 64'h0, 4'd2, v, p);
        n_chk++; if (o_underflow !== 1'b1) begin n_fail++; $display("FAIL full_drain: got uf=%b want 1", o_underflow); end
        do_reset();
        both(PID_SOF, 64'h7, PID_SOF, 64'h7, v, p);
        n_chk++; if ({v, p, o_underflow} !== 3'b101) begin
            n_fail++; $display("FAIL empty_pushpop: got v=%b p=%b uf=%b want 1 0 1", v, p, o_underflow); end
        got(PID_SOF, 64'h7, 4'd2, v, p);
        n_chk++; if ({v, p} !== 2'b11) begin n_fail++; $display("FAIL empty_stored: got v=%b p=%b want 1 1", v, p); end
    endtask

    task automatic test_reset_mid();
        logic v, p;
        do_reset();
        push(PID_OUT, 64'h1, 4'd2);
        push(PID_IN, 64'h2, 4'd2);
        got(PID_OUT, 64'h1, 4'd2, v, p);
        got(PID_SOF, 64'h9, 4'd2, v, p);
        n_chk++; if ({o_nPass, o_nFail} !== {16'd1, 16'd1}) begin
            n_fail++; $display("FAIL mid_counts: got %0d/%0d want 1/1", o_nPass, o_nFail); end
        push(PID_IN, 64'h3, 4'd2);
        @(negedge i_clk); i_rst = 1'b0;
        #1;
        n_chk++; if ({o_nPass, o_nFail, o_overflow, o_underflow} !== 34'h0) begin
            n_fail++; $display("FAIL mid_async: got %0d/%0d of=%b uf=%b want 0/0 0 0", o_nPass, o_nFail, o_overflow, o_underflow); end
        @(negedge i_clk); i_rst = 1'b1;
        got(PID_IN, 64'h2, 4'd2, v, p);
        n_chk++; if ({v, p, o_underflow, o_nFail} !== {3'b101, 16'd1}) begin
            n_fail++; $display("FAIL mid_flush: got v=%b p=%b uf=%b nf=%0d want 1 0 1 1", v, p, o_underflow, o_nFail); end
    endtask

    initial begin
        test_reset();
        test_token();
        test_data();
        test_handshake();
        test_underflow();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
